instr_mem_sync: RTL and testbench

Parametrised synchronous instruction memory for the pipeline fetch stage, succeeding the combinational ROM.
- Registered read: 1-cycle latency, with a fetch valid/stall handshake.
- Runtime load port for programming the memory over the test/debug path.
- Tracks the loaded instruction count; returns NOP for out-of-range fetches.
- Post-reset sweep fills unloaded entries with NOP.

---
 rtl/instr_mem_sync.sv | 87 ++++++++
 tb/tb_instr_mem_sync.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous instruction memory with fetch handshake, load port and post-reset NOP sweep.
module instr_mem_sync #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_SHIFT = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h08000000,
    parameter MEMFILE = "",
    parameter int INIT_COUNT = 0,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_stall,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_oob,
    input  logic                  load_we,
    input  logic [IDX_W:0]        load_index,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_err,
    output logic                  ready,
`ifdef IMEM_FETCH_COUNT_EN
    output logic [IDX_W:0]        instr_count,
    output logic [31:0]           fetch_count
`else
    output logic [IDX_W:0]        instr_count
`endif
);
    typedef enum logic {INIT, READY} state_t;
    state_t state;
    logic [IDX_W:0] ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0] load_next;
    logic in_range, accept, sweep_we, load_ok;

    always_comb begin
        word_addr = fetch_addr >> WORD_SHIFT;
        idx = word_addr[IDX_W-1:0];
        in_range = ((word_addr >> IDX_W) == '0) && ({1'b0, idx} < instr_count);
        accept = fetch_req & ready & ~fetch_stall;
        sweep_we = reset_n & (state == INIT) & ~ptr[IDX_W];
        load_ok = load_we & ready & ~load_index[IDX_W];
        load_next = load_index + (IDX_W+1)'(1);
    end

    always_ff @(posedge clk)
        if (sweep_we) mem[ptr[IDX_W-1:0]] <= NOP_WORD;
        else if (load_ok) mem[load_index[IDX_W-1:0]] <= load_data;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= INIT;
            ptr <= (IDX_W+1)'(INIT_COUNT);
            ready <= 1'b0;
            instr_count <= (IDX_W+1)'(INIT_COUNT);
            fetch_valid <= 1'b0;
            fetch_instr <= NOP_WORD;
            fetch_oob <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (state == INIT) begin
                ptr <= ptr[IDX_W] ? ptr : ptr + (IDX_W+1)'(1);
                state <= ptr[IDX_W] ? READY : INIT;
                ready <= ptr[IDX_W];
            end
            load_err <= load_we & ~load_ok;
            if (load_ok && load_next > instr_count) instr_count <= load_next;
            if (!fetch_stall) begin
                fetch_valid <= accept;
                if (accept) begin
                    fetch_instr <= in_range ? mem[idx] : NOP_WORD;
                    fetch_oob <= ~in_range;
                end
            end
        end

`ifdef IMEM_FETCH_COUNT_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) fetch_count <= '0;
        else if (accept) fetch_count <= fetch_count + 32'd1;
`endif
endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: directed test of instr_mem_sync against a per-edge behavioural model.
module tb_instr_mem_sync;
    localparam logic [31:0] NOP = 32'h08000000;
    logic clk = 1'b0, reset_n = 1'b0;
    logic fetch_req = 1'b0, fetch_stall = 1'b0, load_we = 1'b0;
    logic [31:0] fetch_addr = '0, load_data = '0;
    logic [6:0] load_index = '0;
    logic fetch_valid, fetch_oob, load_err, ready;
    logic [31:0] fetch_instr;
    logic [6:0] instr_count;
`ifdef IMEM_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif
    int n_checks = 0, n_fail = 0;
    bit chk = 1'b0;

    instr_mem_sync dut (
        .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_stall(fetch_stall), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_oob(fetch_oob), .load_we(load_we), .load_index(load_index),
        .load_data(load_data), .load_err(load_err), .ready(ready),
`ifdef IMEM_FETCH_COUNT_EN
        .instr_count(instr_count), .fetch_count(fetch_count)
`else
        .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: edges since reset release decide readiness; memory is an array of words.
    logic [31:0] mmem [64];
    int m_cycles, m_count;
    logic m_valid, m_oob, m_err, m_ready;
    logic [31:0] m_instr, m_fc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cycles = 0; m_count = 0; m_valid = 0; m_oob = 0; m_err = 0;
            m_ready = 0; m_instr = NOP; m_fc = 0;
            for (int i = 0; i < 64; i++) mmem[i] = NOP;
        end else begin
            bit rdy, inr;
            int li;
            rdy = m_cycles >= 65;
            if (!fetch_stall) begin
                m_valid = fetch_req && rdy;
                if (m_valid) begin
                    inr = (fetch_addr < 256) && (int'(fetch_addr / 4) < m_count);
                    m_instr = inr ? mmem[fetch_addr / 4] : NOP;
                    m_oob = !inr;
                    m_fc = m_fc + 1;
                end
            end
            li = int'(load_index);
            m_err = load_we && !(rdy && li < 64);
            if (load_we && rdy && li < 64) begin
                mmem[li] = load_data;
                if (li + 1 > m_count) m_count = li + 1;
            end
            m_cycles++;
            m_ready = m_cycles >= 65;
        end
    end

    always @(negedge clk)
        if (chk) begin
            check("fetch_valid", 64'(fetch_valid), 64'(m_valid));
            check("fetch_instr", 64'(fetch_instr), 64'(m_instr));
            check("fetch_oob", 64'(fetch_oob), 64'(m_oob));
            check("load_err", 64'(load_err), 64'(m_err));
            check("ready", 64'(ready), 64'(m_ready));
            check("instr_count", 64'(instr_count), 64'(m_count));
`ifdef IMEM_FETCH_COUNT_EN
            check("fetch_count", 64'(fetch_count), 64'(m_fc));
`endif
        end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_req = 1; fetch_addr = a;
        tick();
        fetch_req = 0;
    endtask

    task automatic load(input int i, input logic [31:0] d);
        load_we = 1; load_index = 7'(i); load_data = d;
        tick();
        load_we = 0;
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_valid"}, 64'(fetch_valid), 64'd0);
        check({tag, "_instr"}, 64'(fetch_instr), 64'(NOP));
        check({tag, "_oob"}, 64'(fetch_oob), 64'd0);
        check({tag, "_err"}, 64'(load_err), 64'd0);
        check({tag, "_ready"}, 64'(ready), 64'd0);
        check({tag, "_count"}, 64'(instr_count), 64'd0);
    endtask

    localparam logic [31:0] PROG [4] = '{32'hE3A00005, 32'hE3A01000, 32'hE3A02001, 32'hE3500001};
    localparam logic [31:0] SEQ [6] = '{32'h0, 32'h24, 32'hFC, 32'h100, 32'h14, 32'h8};

    initial begin
        int n;
        repeat (3) tick();
        reset_vals("rst");
        chk = 1; reset_n = 1;
        repeat (10) tick();
        check("mid_sweep_ready", 64'(ready), 64'd0);
        #1 reset_n = 0;
        #1 reset_vals("midrst");
        tick();
        reset_n = 1;
        n = 0;
        while (!ready && n < 200) begin
            if (n == 2) begin
                load_we = 1; load_index = 7'd2; load_data = 32'h12345678;
                fetch_req = 1; fetch_addr = 0;
            end
            if (n == 3) begin
                check("init_load_err", 64'(load_err), 64'd1);
                check("init_fetch_ignored", 64'(fetch_valid), 64'd0);
                load_we = 0; fetch_req = 0;
            end
            tick();
            n++;
        end
        check("sweep_cycles", 64'(n), 64'd65);
        check("init_count_kept", 64'(instr_count), 64'd0);

        fetch(32'h0);
        check("empty_valid", 64'(fetch_valid), 64'd1);
        check("empty_instr", 64'(fetch_instr), 64'(NOP));
        check("empty_oob", 64'(fetch_oob), 64'd1);

        for (int i = 0; i < 4; i++) load(i, PROG[i]);
        check("count4", 64'(instr_count), 64'd4);
        fetch(32'h8);
        check("f8_instr", 64'(fetch_instr), 64'hE3A02001);
        check("f8_oob", 64'(fetch_oob), 64'd0);
        fetch(32'h10);
        check("f10_instr", 64'(fetch_instr), 64'(NOP));
        check("f10_oob", 64'(fetch_oob), 64'd1);

        fetch(32'h4);
        fetch_stall = 1; fetch_req = 1; fetch_addr = 32'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 64'(fetch_valid), 64'd1);
            check("stall_instr", 64'(fetch_instr), 64'hE3A01000);
        end
        fetch_stall = 0; fetch_req = 0;
        tick();
        check("drop_valid", 64'(fetch_valid), 64'd0);
        check("drop_instr", 64'(fetch_instr), 64'hE3A01000);

        load_we = 1; load_index = 7'd1; load_data = 32'hAAAA5555;
        fetch(32'h4);
        load_we = 0;
        check("rbw_old", 64'(fetch_instr), 64'hE3A01000);
        fetch(32'h4);
        check("rbw_new", 64'(fetch_instr), 64'hAAAA5555);

        load(64, 32'hDEADBEEF);
        check("oob_load_err", 64'(load_err), 64'd1);
        check("oob_load_count", 64'(instr_count), 64'd4);
        tick();
        check("load_err_pulse", 64'(load_err), 64'd0);
        fetch(32'h0100_0000);
        check("upper_instr", 64'(fetch_instr), 64'(NOP));
        check("upper_oob", 64'(fetch_oob), 64'd1);

        load(10, 32'h0000000A);
        check("count11", 64'(instr_count), 64'd11);
        fetch(32'h24);
        check("swept_instr", 64'(fetch_instr), 64'(NOP));
        check("swept_oob", 64'(fetch_oob), 64'd0);
        load(63, 32'h3F3F3F3F);
        load(5, 32'h55555555);
        check("count_sat", 64'(instr_count), 64'd64);
        fetch_req = 1;
        for (int i = 0; i < 6; i++) begin
            fetch_addr = SEQ[i];
            tick();
        end
        fetch_req = 0;
        check("last_seq", 64'(fetch_instr), 64'hE3A02001);
        tick();
        tick();
        chk = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
